// File: rtl/countdown_display_pkg.sv
// rtl/countdown_display_pkg.sv - shared constants for the countdown display slice
//
// Purpose: FSM state encoding, blank codes and the active-low 7-segment
// table used by countdown_display and bcd_to_seg7.
// Ports: none (package).

package countdown_display_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_FLASH = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // All segments off (active-low) and the BCD code that renders blank
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] BCD_BLANK = 4'd10;

  // Active-low segments, bit0=a .. bit6=g; entry N is digit N
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/countdown_display_seg7.sv
// rtl/countdown_display_seg7.sv - BCD digit to active-low 7-segment decoder
//
// Purpose: combinational decode of one BCD digit; codes 10-15 render blank.
// Ports:
//   bcd  in  4  BCD digit (0-9 valid, 10-15 blank)
//   seg  out 7  active-low segments, bit0=a .. bit6=g

module bcd_to_seg7
  import countdown_display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (bcd <= 4'd9) begin
      seg = SEG_TABLE[bcd];
    end
  end

endmodule

// File: rtl/countdown_display.sv
// rtl/countdown_display.sv - two-digit countdown display with expiry flash
//
// Purpose: registers the countdown digits, decodes them to two active-low
// 7-segment displays with optional leading-zero suppression, and detects a
// nonzero-to-00 transition. On expiry the display flashes "00" for
// BLINK_TOGGLES half-periods, then holds "00" with expired set until ack.
// Ports:
//   clock        in  1  system clock
//   reset        in  1  synchronous, active-high reset
//   digit1       in  4  ones digit (0-9 valid, 10-15 blank)
//   digit2       in  4  tens digit, same coding
//   blank_lz     in  1  suppress a leading zero on the tens display
//   ack          in  1  clears the expiry alarm
//   hex0         out 7  ones display, active-low, bit0=a .. bit6=g
//   hex1         out 7  tens display, same format
//   expired      out 1  high in FLASH and HOLD
//   alarm_pulse  out 1  one-cycle pulse on entry to FLASH

module countdown_display
  import countdown_display_pkg::*;
#(
  parameter int BLINK_HALF    = 25000000,
  parameter int BLINK_TOGGLES = 6,
  parameter int CNT_W         = 25
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic       blank_lz,
  input  logic       ack,
  output logic [6:0] hex0,
  output logic [6:0] hex1,
  output logic       expired,
  output logic       alarm_pulse
);

  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);
  localparam logic [15:0]      TOG_LIMIT  = 16'(BLINK_TOGGLES);

  logic [3:0]       d1_q, d2_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic [15:0]      tog_cnt_q, tog_cnt_d;
  logic             phase_q, phase_d;   // 1 = ON (digits visible)

  logic valid, zero, nonzero, invalid;
  logic blink_wrap;
  logic [6:0] seg0, seg1;
  logic [6:0] hex0_d, hex1_d;

  bcd_to_seg7 u_seg_ones (.bcd(d1_q), .seg(seg0));
  bcd_to_seg7 u_seg_tens (.bcd(d2_q), .seg(seg1));

  always_comb begin
    valid   = (d1_q <= 4'd9) && (d2_q <= 4'd9);
    zero    = valid && (d1_q == 4'd0) && (d2_q == 4'd0);
    nonzero = valid && !zero;
    invalid = !valid;
  end

  assign blink_wrap = (blink_cnt_q == BLINK_LAST);

  always_comb begin
    state_d     = state_q;
    blink_cnt_d = blink_cnt_q;
    tog_cnt_d   = tog_cnt_q;
    phase_d     = phase_q;

    case (state_q)
      ST_IDLE: begin
        // A bare 00 here never alarms: expiry needs a prior nonzero count
        if (nonzero) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (invalid) begin
          state_d = ST_IDLE;
        end else if (zero) begin
          // ack arriving with the first zero cancels the alarm outright
          state_d = ack ? ST_IDLE : ST_FLASH;
        end
      end
      ST_FLASH: begin
        if (ack || invalid) begin
          state_d = ST_IDLE;
        end else if (nonzero) begin
          state_d = ST_ARMED;
        end else if (tog_cnt_q == TOG_LIMIT) begin
          // Only reachable on the first FLASH cycle when BLINK_TOGGLES is 0
          state_d = ST_HOLD;
        end else begin
          if (blink_wrap) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
            tog_cnt_d   = tog_cnt_q + 16'd1;
            if (tog_cnt_q + 16'd1 == TOG_LIMIT) state_d = ST_HOLD;
          end else begin
            blink_cnt_d = blink_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_HOLD: begin
        if (ack || invalid) begin
          state_d = ST_IDLE;
        end else if (nonzero) begin
          state_d = ST_ARMED;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Counters only live inside a FLASH episode; entry or exit starts fresh
    if (state_d != ST_FLASH || state_q != ST_FLASH) begin
      blink_cnt_d = '0;
      tog_cnt_d   = '0;
      phase_d     = 1'b1;
    end
  end

  // Display follows the next state so the hex change lands with the state
  always_comb begin
    hex0_d = seg0;
    hex1_d = seg1;
    if (blank_lz && (d2_q == 4'd0) && (d1_q <= 4'd9)) begin
      hex1_d = SEG_BLANK;
    end
    if (state_d == ST_FLASH && !phase_d) begin
      hex0_d = SEG_BLANK;
      hex1_d = SEG_BLANK;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      d1_q        <= BCD_BLANK;
      d2_q        <= BCD_BLANK;
      state_q     <= ST_IDLE;
      blink_cnt_q <= '0;
      tog_cnt_q   <= '0;
      phase_q     <= 1'b0;
      hex0        <= SEG_BLANK;
      hex1        <= SEG_BLANK;
      expired     <= 1'b0;
      alarm_pulse <= 1'b0;
    end else begin
      d1_q        <= digit1;
      d2_q        <= digit2;
      state_q     <= state_d;
      blink_cnt_q <= blink_cnt_d;
      tog_cnt_q   <= tog_cnt_d;
      phase_q     <= phase_d;
      hex0        <= hex0_d;
      hex1        <= hex1_d;
      expired     <= (state_d == ST_FLASH) || (state_d == ST_HOLD);
      alarm_pulse <= (state_d == ST_FLASH) && (state_q != ST_FLASH);
    end
  end

endmodule
